// File: rtl/frame_capture_ctrl.sv
// Camera frame capture engine: frame/line sequencing with geometry checks, optional
// 2:1 horizontal decimation, and a show-ahead output FIFO whose entries carry a SOF tag.
module frame_capture_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_ADDR_LEN = 9,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_d,
    input  logic                  in_valid,
    input  logic                  in_vsync,
    input  logic                  in_hsync,
    input  logic                  frame_req,
    input  logic [7:0]            frame_count,
    input  logic [1:0]            mode,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] out_d,
    output logic                  out_sof,
    output logic                  out_rdy,
    input  logic                  out_next,
    output logic                  capture_active,
    output logic [15:0]           frames_done,
    output logic                  err_overflow,
    output logic                  err_line,
    output logic                  err_frame,
    input  logic                  err_clr
);

    localparam int XW    = $clog2(H_ACTIVE + 1);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    localparam int DEPTH = 1 << FIFO_ADDR_LEN;
    localparam logic [XW-1:0]          X_END     = XW'(H_ACTIVE);
    localparam logic [YW-1:0]          Y_END     = YW'(V_ACTIVE);
    localparam logic [FIFO_ADDR_LEN:0] FIFO_FULL = {1'b1, {FIFO_ADDR_LEN{1'b0}}};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t                  state, state_nxt;
    logic [XW-1:0]           x, x_nxt, x_step;
    logic [YW-1:0]           y, y_nxt, y_inc;
    logic                    sof_pending, sof_nxt;
    logic [7:0]              remaining, remaining_nxt;
    logic [1:0]              mode_q, mode_nxt;
    logic                    stop_req, stop_req_nxt;
    logic [15:0]             frames_nxt;
    logic                    enq, set_line, set_frame, frame_end, last_frame;

    // Input stage: pixel and sync registers line up so an edge and its pixel share a cycle.
    logic [DATA_WIDTH-1:0]   pix_d;
    logic                    pix_valid;
    logic                    vs_q1, vs_q2, hs_q1, hs_q2;
    logic                    vs_fall, hs_fall;

    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [FIFO_ADDR_LEN-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_LEN:0]  count;
    logic                    full, rd_en, wr_en;

    assign vs_fall = vs_q2 & ~vs_q1;
    assign hs_fall = hs_q2 & ~hs_q1;
    assign y_inc   = y + YW'(1);

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        x_step        = x;
        sof_nxt       = sof_pending;
        remaining_nxt = remaining;
        mode_nxt      = mode_q;
        stop_req_nxt  = stop_req;
        frames_nxt    = frames_done;
        enq           = 1'b0;
        set_line      = 1'b0;
        set_frame     = 1'b0;
        frame_end     = 1'b0;
        last_frame    = 1'b0;
        case (state)
            IDLE: if (frame_req) begin
                state_nxt     = ARMED;
                remaining_nxt = (frame_count == 8'd0) ? 8'd1 : frame_count;
                mode_nxt      = mode;
            end
            ARMED: if (stop) begin
                state_nxt = IDLE;
            end else if (vs_fall) begin
                state_nxt = CAPTURE;
                x_nxt     = '0;
                y_nxt     = '0;
                sof_nxt   = 1'b1;
            end
            CAPTURE: begin
                stop_req_nxt = stop_req | stop;
                if (vs_fall) begin
                    set_frame = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    if (pix_valid) begin
                        if (x == X_END) begin
                            set_line = 1'b1;
                        end else begin
                            if (!(mode_q[0] && x[0])) begin
                                enq     = 1'b1;
                                sof_nxt = 1'b0;
                            end
                            x_step = x + XW'(1);
                        end
                    end
                    x_nxt = x_step;
                    if (hs_fall) begin
                        if (x_step != X_END && x_step != '0) set_line = 1'b1;
                        if (x_step != '0) begin
                            y_nxt = y_inc;
                            if (y_inc == Y_END) frame_end = 1'b1;
                        end
                        x_nxt = '0;
                    end
                end
                if (frame_end) begin
                    frames_nxt   = frames_done + 16'd1;
                    if (!mode_q[1]) remaining_nxt = remaining - 8'd1;
                    last_frame   = (!mode_q[1] && remaining == 8'd1) || stop || stop_req;
                    stop_req_nxt = 1'b0;
                    if (last_frame) begin
                        state_nxt = IDLE;
                    end else if (vs_fall) begin
                        x_nxt   = '0;
                        y_nxt   = '0;
                        sof_nxt = 1'b1;
                    end else begin
                        state_nxt = ARMED;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            sof_pending <= 1'b0;
            remaining   <= '0;
            mode_q      <= '0;
            stop_req    <= 1'b0;
            frames_done <= '0;
            pix_d       <= '0;
            pix_valid   <= 1'b0;
            vs_q1       <= 1'b1;
            vs_q2       <= 1'b1;
            hs_q1       <= 1'b1;
            hs_q2       <= 1'b1;
        end else begin
            state       <= state_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            sof_pending <= sof_nxt;
            remaining   <= remaining_nxt;
            mode_q      <= mode_nxt;
            stop_req    <= stop_req_nxt;
            frames_done <= frames_nxt;
            pix_d       <= in_d;
            pix_valid   <= in_valid;
            vs_q1       <= in_vsync;
            vs_q2       <= vs_q1;
            hs_q1       <= in_hsync;
            hs_q2       <= hs_q1;
        end
    end

    assign full    = (count == FIFO_FULL);
    assign out_rdy = (count != '0);
    assign rd_en   = out_next & out_rdy;
    // A dequeue in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_en   = enq & (~full | rd_en);

    // NOTE: the storage array has no reset; only pointers and count define FIFO contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {sof_pending, pix_d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
            err_line     <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (enq && !wr_en) err_overflow <= 1'b1;
            else if (err_clr)  err_overflow <= 1'b0;
            if (set_line)      err_line <= 1'b1;
            else if (err_clr)  err_line <= 1'b0;
            if (set_frame)     err_frame <= 1'b1;
            else if (err_clr)  err_frame <= 1'b0;
        end
    end

    assign out_d          = out_rdy ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign out_sof        = out_rdy ? mem[rd_ptr][DATA_WIDTH] : 1'b0;
    assign capture_active = (state != IDLE) | out_rdy;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a small 8x4 geometry with an 8-entry FIFO:
// a scenario table for clean captures plus hand sequences for error and reset corners.
module tb_frame_capture_ctrl;

    localparam int DW = 16;
    localparam int AL = 3;
    localparam int H  = 8;
    localparam int V  = 4;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] in_d;
    logic          in_valid, in_vsync, in_hsync;
    logic          frame_req;
    logic [7:0]    frame_count;
    logic [1:0]    mode;
    logic          stop;
    logic [DW-1:0] out_d;
    logic          out_sof, out_rdy, out_next;
    logic          capture_active;
    logic [15:0]   frames_done;
    logic          err_overflow, err_line, err_frame, err_clr;

    frame_capture_ctrl #(
        .DATA_WIDTH(DW), .FIFO_ADDR_LEN(AL), .H_ACTIVE(H), .V_ACTIVE(V)
    ) dut (
        .clk(clk), .resetn(resetn), .in_d(in_d), .in_valid(in_valid),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .frame_req(frame_req),
        .frame_count(frame_count), .mode(mode), .stop(stop),
        .out_d(out_d), .out_sof(out_sof), .out_rdy(out_rdy), .out_next(out_next),
        .capture_active(capture_active), .frames_done(frames_done),
        .err_overflow(err_overflow), .err_line(err_line), .err_frame(err_frame),
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] mode;
        logic [7:0] fcount;
        int         frames_sent;
        int         exp_pix;
        int         exp_sof;
        int         exp_frames;
    } scen_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [DW:0] rx_q[$];
    logic [DW:0] exp_q[$];
    bit          drain_en  = 1'b0;
    bit          dec_model = 1'b0;
    bit          sof_model = 1'b0;
    int          exp_frames = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Sink: pops one entry per cycle while enabled, recording {sof, data}.
    initial begin
        out_next = 1'b0;
        forever begin
            @(negedge clk);
            if (drain_en && out_rdy && resetn) begin
                rx_q.push_back({out_sof, out_d});
                out_next = 1'b1;
            end else begin
                out_next = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic start(logic [1:0] m, logic [7:0] fc);
        mode = m; frame_count = fc; frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        tick();
    endtask

    task automatic vsync_edge();
        in_vsync = 1'b0;
        tick();
        in_vsync = 1'b1;
        tick();
        tick();
        sof_model = 1'b1;
    endtask

    task automatic send_pixel(int fr, int ln, int xi, bit cap);
        in_valid = 1'b1;
        in_d = DW'((fr << 8) | (ln << 4) | xi);
        if (cap && xi < H && (!dec_model || (xi % 2) == 0)) begin
            exp_q.push_back({sof_model, in_d});
            sof_model = 1'b0;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_line(int len, int fr, int ln, bit cap);
        for (int i = 0; i < len; i++) send_pixel(fr, ln, i, cap);
        in_hsync = 1'b0;
        tick();
        in_hsync = 1'b1;
        tick();
    endtask

    task automatic send_frame(int fr, bit cap);
        vsync_edge();
        for (int ln = 0; ln < V; ln++) send_line(H, fr, ln, cap);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        repeat (3) tick();
        while (out_rdy && n < 200) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check({name, "_drain_done"}, 32'(n < 200), 1);
    endtask

    function automatic int stream_errs();
        int e = 0;
        if (rx_q.size() != exp_q.size()) e++;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) e++;
        return e;
    endfunction

    function automatic int sof_count();
        int c = 0;
        foreach (rx_q[i]) if (rx_q[i][DW]) c++;
        return c;
    endfunction

    task automatic clear_streams();
        rx_q.delete();
        exp_q.delete();
    endtask

    scen_t tbl[4];

    initial begin
        tbl[0] = '{mode: 2'd0, fcount: 8'd2, frames_sent: 2, exp_pix: 64, exp_sof: 2, exp_frames: 2};
        tbl[1] = '{mode: 2'd1, fcount: 8'd1, frames_sent: 1, exp_pix: 16, exp_sof: 1, exp_frames: 1};
        tbl[2] = '{mode: 2'd0, fcount: 8'd0, frames_sent: 2, exp_pix: 32, exp_sof: 1, exp_frames: 1};
        tbl[3] = '{mode: 2'd1, fcount: 8'd3, frames_sent: 3, exp_pix: 48, exp_sof: 3, exp_frames: 3};

        resetn = 1'b0; in_d = '0; in_valid = 1'b0; in_vsync = 1'b1; in_hsync = 1'b1;
        frame_req = 1'b0; frame_count = '0; mode = '0; stop = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        check("reset_out_rdy", out_rdy, 0);
        check("reset_out_sof", out_sof, 0);
        check("reset_out_d", out_d, 0);
        check("reset_capture_active", capture_active, 0);
        check("reset_frames_done", frames_done, 0);
        check("reset_errors", {err_overflow, err_line, err_frame}, 0);
        resetn = 1'b1;
        tick();

        for (int s = 0; s < 4; s++) begin
            int eff;
            clear_streams();
            dec_model = tbl[s].mode[0];
            drain_en  = 1'b1;
            eff = (tbl[s].fcount == 8'd0) ? 1 : int'(tbl[s].fcount);
            start(tbl[s].mode, tbl[s].fcount);
            for (int f = 0; f < tbl[s].frames_sent; f++) send_frame(f, f < eff);
            exp_frames += tbl[s].exp_frames;
            wait_drain($sformatf("s%0d", s));
            check($sformatf("s%0d_pixels", s), rx_q.size(), tbl[s].exp_pix);
            check($sformatf("s%0d_sof_count", s), sof_count(), tbl[s].exp_sof);
            check($sformatf("s%0d_stream", s), stream_errs(), 0);
            check($sformatf("s%0d_frames_done", s), frames_done, exp_frames);
            check($sformatf("s%0d_errors", s), {err_overflow, err_line, err_frame}, 0);
            check($sformatf("s%0d_idle", s), capture_active, 0);
        end
        dec_model = 1'b0;

        // Long line then short line.
        clear_streams();
        start(2'd0, 8'd1);
        vsync_edge();
        send_line(10, 0, 0, 1'b1);
        send_line(6, 0, 1, 1'b1);
        send_line(H, 0, 2, 1'b1);
        send_line(H, 0, 3, 1'b1);
        exp_frames++;
        wait_drain("line");
        check("line_pixels", rx_q.size(), 30);
        check("line_stream", rx_q.size() > 0 ? stream_errs() : 1, 0);
        check("line_err_line", err_line, 1);
        check("line_frames_done", frames_done, exp_frames);
        check("line_idle", capture_active, 0);
        pulse_clr();
        check("line_err_clr", err_line, 0);

        // Overflow with the sink stalled, then an early vsync ends the frame.
        clear_streams();
        drain_en = 1'b0;
        start(2'd0, 8'd1);
        vsync_edge();
        send_line(H, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) send_pixel(0, 1, i, 1'b1);
        repeat (3) tick();
        check("ovf_out_rdy", out_rdy, 1);
        check("ovf_err_overflow", err_overflow, 1);
        check("ovf_head_sof", out_sof, 1);
        check("ovf_head_d", out_d, exp_q[0][DW-1:0]);
        while (exp_q.size() > 8) void'(exp_q.pop_back());
        drain_en = 1'b1;
        wait_drain("ovf");
        check("ovf_stream", stream_errs(), 0);
        vsync_edge();
        exp_frames++;
        repeat (2) tick();
        check("ovf_err_frame", err_frame, 1);
        check("ovf_frames_done", frames_done, exp_frames);
        check("ovf_idle", capture_active, 0);
        pulse_clr();
        check("ovf_errs_cleared", {err_overflow, err_line, err_frame}, 0);

        // Continuous capture, stop during frame 3.
        clear_streams();
        start(2'd2, 8'd0);
        send_frame(0, 1'b1);
        send_frame(1, 1'b1);
        vsync_edge();
        send_line(H, 2, 0, 1'b1);
        send_line(H, 2, 1, 1'b1);
        pulse_stop();
        send_line(H, 2, 2, 1'b1);
        send_line(H, 2, 3, 1'b1);
        vsync_edge();
        send_line(H, 3, 0, 1'b0);
        exp_frames += 3;
        wait_drain("cont");
        check("cont_pixels", rx_q.size(), 96);
        check("cont_sof_count", sof_count(), 3);
        check("cont_stream", stream_errs(), 0);
        check("cont_frames_done", frames_done, exp_frames);
        check("cont_idle", capture_active, 0);
        check("cont_errors", {err_overflow, err_line, err_frame}, 0);

        // Early vsync after two lines restarts capture on the same edge.
        clear_streams();
        start(2'd2, 8'd0);
        vsync_edge();
        send_line(H, 0, 0, 1'b1);
        send_line(H, 0, 1, 1'b1);
        vsync_edge();
        send_line(H, 1, 0, 1'b1);
        send_line(H, 1, 1, 1'b1);
        pulse_stop();
        send_line(H, 1, 2, 1'b1);
        send_line(H, 1, 3, 1'b1);
        exp_frames += 2;
        wait_drain("early");
        check("early_pixels", rx_q.size(), 48);
        check("early_sof_count", sof_count(), 2);
        check("early_stream", stream_errs(), 0);
        check("early_err_frame", err_frame, 1);
        check("early_err_line", err_line, 0);
        check("early_frames_done", frames_done, exp_frames);
        check("early_idle", capture_active, 0);
        pulse_clr();

        // Reset mid-frame, then a fresh capture.
        clear_streams();
        drain_en = 1'b0;
        start(2'd0, 8'd1);
        vsync_edge();
        send_line(H, 0, 0, 1'b1);
        tick();
        check("rst_pre_out_rdy", out_rdy, 1);
        resetn = 1'b0;
        #1;
        check("rst_out_rdy", out_rdy, 0);
        check("rst_capture_active", capture_active, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_head", {out_sof, out_d}, 0);
        tick();
        resetn = 1'b1;
        tick();
        exp_frames = 0;
        clear_streams();
        drain_en = 1'b1;
        start(2'd0, 8'd1);
        send_frame(5, 1'b1);
        exp_frames++;
        wait_drain("rst");
        check("rst_pixels", rx_q.size(), 32);
        check("rst_stream", stream_errs(), 0);
        check("rst_frames_done_after", frames_done, exp_frames);
        check("rst_idle", capture_active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
